lsu_stage: RTL and testbench
============================

# lsu_stage

Load/store stage of the milano core, directly downstream of the execute stage. Accepts one memory operation per handshake, using the execute stage's computed effective address and store data. Drives a single-outstanding req/gnt/rvalid data-bus transaction and aligns and extends load data. Produces the register-file write port for loads.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  execute stage presents a memory op
- lsu_ready_o  out  1  stage can accept an op this cycle
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_type_i  in  2  lsu_type_e: LSU_BYTE=2'b00, LSU_HALF=2'b01, LSU_WORD=2'b10
- lsu_sext_i  in  1  sign-extend load result (LB/LH)
- lsu_addr_i  in  32  effective address from the ALU
- lsu_wdata_i  in  32  store data (rs2)
- rd_addr_i  in  5  load destination
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- data_we_o  out  1  bus write
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-replicated store data
- data_rvalid_i  in  1  response valid (loads and stores)
- data_rdata_i  in  32  response data
- reg_we_o  out  1  register write strobe, one cycle
- wr_addr_o  out  5  write address
- rd_wdata_o  out  32  aligned, extended load data
- misaligned_o  out  1  one-cycle misaligned-access pulse

## Operation
- FSM lsu_state_e: IDLE, REQ, WAIT_RSP.
- lsu_ready_o = (state == IDLE).
- Accept = ex_valid_i & lsu_ready_o. On accept, register we, type, sext, addr, wdata and rd.
- Misaligned check on accept: HALF with addr[0]=1, or WORD with addr[1:0]!=0.
  - Misaligned: no bus access; misaligned_o=1 next cycle; stay IDLE.
  - Aligned: go to REQ.
- REQ: data_req_o=1. addr/we/be/wdata held stable until grant. gnt -> WAIT_RSP.
- WAIT_RSP: data_req_o=0. On rvalid -> IDLE.
  - For a load, register the result: reg_we_o=(rd!=0), wr_addr_o=rd, rd_wdata_o=aligned data.
  - For a store, no register write.
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0]
  - HALF: 4'b0011<<addr[1:0]
  - WORD: 4'b1111
- Store data:
  - BYTE: {4{wdata[7:0]}}
  - HALF: {2{wdata[15:0]}}
  - WORD: unchanged
- Load data: shift = rdata >> (8*addr[1:0]). BYTE/HALF then zero- or sign-extended per sext. WORD unchanged.
- Ignored events:
  - rvalid in IDLE or REQ
  - gnt outside REQ

## Timing
- Reset values: state=IDLE. data_req_o, data_we_o, reg_we_o and misaligned_o are 0. data_be_o, data_addr_o, data_wdata_o, wr_addr_o and rd_wdata_o are 0.
- Accept at cycle t -> data_req_o high at t+1.
- Grant at cycle g -> rvalid legal from g+1.
- rvalid at cycle r -> reg_we_o high at r+1 for exactly one cycle. lsu_ready_o high at r+1.
- Best-case load: accept t, gnt t+1, rvalid t+2, writeback t+3. Throughput is one op per 3 cycles minimum.
- Misaligned: accept t -> misaligned_o at t+1; ready stays high; next op may be accepted at t+1.
- Reset asserted mid-transaction: immediate IDLE, req drops asynchronously. A late rvalid after reset is ignored.
- Writeback registers hold their value when reg_we_o=0; only the reg_we_o strobe is a pulse.

## Structure
- milano_pkg holds:
  - lsu_type_e and lsu_state_e
  - LSU_BYTE/HALF/WORD encodings
- Sub-module lsu_data_align (combinational) holds the be, wdata replication, and rdata shift/extend logic.
- lsu_stage holds the FSM, operand registers and writeback registers.

## Test plan
- LW addr=0x100, rdata=0xDEADBEEF, gnt and rvalid immediate, rd=5 -> data_addr_o=0x100, be=4'b1111; reg_we_o at t+3, wr_addr_o=5, rd_wdata_o=0xDEADBEEF.
- LB sext=1 addr=0x103, rdata=0x80FFFFFF -> be=4'b1000, rd_wdata_o=0xFFFFFF80. Same with LBU -> 0x00000080.
- SH addr=0x202, wdata=0x1234ABCD -> data_addr_o=0x200, be=4'b1100, data_wdata_o=0xABCDABCD, we=1; no reg_we_o after rvalid.
- LW addr=0x101 -> misaligned_o pulse at t+1, data_req_o never asserted, lsu_ready_o stays 1.
- gnt withheld 4 cycles -> req, addr, be and wdata stable throughout; lsu_ready_o=0 until the cycle after rvalid; back-to-back op accepted then.
- Reset asserted in WAIT_RSP, rvalid pulsed after release -> outputs at reset values, no reg_we_o; LW with rd=0 completes with reg_we_o=0.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared types for the milano core load/store path.
package milano_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10
  } lsu_state_e;

  // The unused type encoding is treated like a word access.
  function automatic logic is_misaligned(lsu_type_e t, logic [1:0] off);
    case (t)
      LSU_BYTE: return 1'b0;
      LSU_HALF: return off[0];
      default:  return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Single-outstanding req/gnt/rvalid data-bus interface.
interface lsu_stage_if;

  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering: store-side enables/replication and load-side shift/extend.
module lsu_data_align
  import milano_pkg::*;
(
    input  lsu_type_e   st_type_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  lsu_type_e   ld_type_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_sext_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = st_wdata_i;
        case (st_type_i)
            LSU_BYTE: begin
                be_o    = 4'b0001 << st_off_i;
                wdata_o = {4{st_wdata_i[7:0]}};
            end
            LSU_HALF: begin
                be_o    = 4'b0011 << st_off_i;
                wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = shifted;
        case (ld_type_i)
            LSU_BYTE: ld_data_o = {{24{ld_sext_i & shifted[7]}}, shifted[7:0]};
            LSU_HALF: ld_data_o = {{16{ld_sext_i & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: accepts one memory op, runs one bus transaction, writes back load data.
module lsu_stage
  import milano_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ex_valid_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  lsu_type_e   lsu_type_i,
    input  logic        lsu_sext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [4:0]  rd_addr_i,
    lsu_stage_if.master data_if,
    output logic        reg_we_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] rd_wdata_o,
    output logic        misaligned_o
);

    lsu_state_e  state_q;
    lsu_type_e   type_q;
    logic        sext_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        req_q;
    logic        bus_we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        reg_we_q;
    logic [4:0]  wr_addr_q;
    logic [31:0] rd_wdata_q;
    logic        misal_q;

    logic        accept;
    logic        misal;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] ld_data;

    assign lsu_ready_o = (state_q == IDLE);
    assign accept      = ex_valid_i & lsu_ready_o;
    assign misal       = is_misaligned(lsu_type_i, lsu_addr_i[1:0]);

    lsu_data_align u_align (
        .st_type_i  (lsu_type_i),
        .st_off_i   (lsu_addr_i[1:0]),
        .st_wdata_i (lsu_wdata_i),
        .be_o       (be_new),
        .wdata_o    (wdata_new),
        .ld_type_i  (type_q),
        .ld_off_i   (off_q),
        .ld_sext_i  (sext_q),
        .rdata_i    (data_if.rdata),
        .ld_data_o  (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            type_q     <= LSU_BYTE;
            sext_q     <= 1'b0;
            off_q      <= 2'b00;
            rd_q       <= 5'd0;
            req_q      <= 1'b0;
            bus_we_q   <= 1'b0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            reg_we_q   <= 1'b0;
            wr_addr_q  <= 5'd0;
            rd_wdata_q <= 32'd0;
            misal_q    <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            misal_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        // A misaligned op is dropped here; the bus never sees it.
                        if (misal) begin
                            misal_q <= 1'b1;
                        end else begin
                            state_q  <= REQ;
                            req_q    <= 1'b1;
                            bus_we_q <= lsu_we_i;
                            addr_q   <= {lsu_addr_i[31:2], 2'b00};
                            be_q     <= be_new;
                            wdata_q  <= wdata_new;
                            type_q   <= lsu_type_i;
                            sext_q   <= lsu_sext_i;
                            off_q    <= lsu_addr_i[1:0];
                            rd_q     <= rd_addr_i;
                        end
                    end
                end
                REQ: begin
                    if (data_if.gnt) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (data_if.rvalid) begin
                        state_q <= IDLE;
                        if (!bus_we_q) begin
                            reg_we_q   <= (rd_q != 5'd0);
                            wr_addr_q  <= rd_q;
                            rd_wdata_q <= ld_data;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_if.req   = req_q;
    assign data_if.addr  = addr_q;
    assign data_if.we    = bus_we_q;
    assign data_if.be    = be_q;
    assign data_if.wdata = wdata_q;
    assign reg_we_o      = reg_we_q;
    assign wr_addr_o     = wr_addr_q;
    assign rd_wdata_o    = rd_wdata_q;
    assign misaligned_o  = misal_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed scenarios plus randomized ops against a reference model.
module tb_lsu_stage;
    import milano_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic        ex_valid;
    logic        lsu_ready;
    logic        lsu_we;
    lsu_type_e   lsu_type;
    logic        lsu_sext;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic [4:0]  wr_addr;
    logic [31:0] rd_wdata;
    logic        misaligned;

    int checks;
    int failures;

    lsu_stage_if bus ();

    lsu_stage dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid),
        .lsu_ready_o  (lsu_ready),
        .lsu_we_i     (lsu_we),
        .lsu_type_i   (lsu_type),
        .lsu_sext_i   (lsu_sext),
        .lsu_addr_i   (lsu_addr),
        .lsu_wdata_i  (lsu_wdata),
        .rd_addr_i    (rd_addr),
        .data_if      (bus),
        .reg_we_o     (reg_we),
        .wr_addr_o    (wr_addr),
        .rd_wdata_o   (rd_wdata),
        .misaligned_o (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: lane arithmetic straight from the access rules.
    function automatic logic [3:0] m_be(int t, int off);
        if (t == 0) return 4'(1 << off);
        if (t == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(int t, logic [31:0] w);
        if (t == 0) return (w & 32'hFF) * 32'h0101_0101;
        if (t == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_load(int t, bit sext, int off, logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * off);
        if (t == 0) begin
            v = v & 32'hFF;
            if (sext && v >= 32'd128) v = v - 32'd256;
        end else if (t == 1) begin
            v = v & 32'hFFFF;
            if (sext && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic bit m_misal(int t, int off);
        if (t == 1) return (off % 2) != 0;
        if (t == 2) return off != 0;
        return 1'b0;
    endfunction

    // Observations captured by run_op for the scenario tasks to judge.
    int          o_wait;
    logic        o_ready_ok, o_ready_post, o_misal, o_req, o_we, o_stable;
    logic        o_reg_we, o_ready_after;
    logic [31:0] o_addr, o_wdata, o_rdwdata;
    logic [3:0]  o_be;
    logic [4:0]  o_wraddr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit we, input int t, input bit sext, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int gnt_wait,
                          input int rsp_wait, input logic [31:0] rdata, input bit noise);
        o_wait = 0;
        while (lsu_ready !== 1'b1 && o_wait < 20) begin
            step();
            o_wait++;
        end
        o_ready_ok = (lsu_ready === 1'b1);
        ex_valid  = 1'b1;
        lsu_we    = we;
        lsu_type  = lsu_type_e'(t[1:0]);
        lsu_sext  = sext;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        rd_addr   = rd;
        step();
        ex_valid  = 1'b0;
        lsu_addr  = $urandom;
        lsu_wdata = $urandom;
        rd_addr   = 5'($urandom);
        o_misal      = misaligned;
        o_req        = bus.req;
        o_addr       = bus.addr;
        o_be         = bus.be;
        o_wdata      = bus.wdata;
        o_we         = bus.we;
        o_ready_post = lsu_ready;
        o_stable     = 1'b1;
        o_reg_we     = 1'b0;
        if (m_misal(t, int'(addr[1:0]))) return;
        for (int i = 0; i < gnt_wait; i++) begin
            if (noise) begin
                bus.rvalid = 1'($urandom);
                bus.rdata  = $urandom;
            end
            step();
            if (bus.req !== 1'b1 || bus.addr !== o_addr || bus.be !== o_be ||
                bus.wdata !== o_wdata || bus.we !== o_we || lsu_ready !== 1'b0 ||
                reg_we !== 1'b0)
                o_stable = 1'b0;
        end
        bus.rvalid = 1'b0;
        bus.gnt    = 1'b1;
        step();
        bus.gnt = 1'b0;
        for (int i = 0; i < rsp_wait; i++) begin
            if (noise) bus.gnt = 1'($urandom);
            step();
            if (bus.req !== 1'b0 || lsu_ready !== 1'b0 || reg_we !== 1'b0) o_stable = 1'b0;
        end
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = rdata;
        step();
        bus.rvalid    = 1'b0;
        bus.rdata     = $urandom;
        o_reg_we      = reg_we;
        o_wraddr      = wr_addr;
        o_rdwdata     = rd_wdata;
        o_ready_after = lsu_ready;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        step();
        checks++;
        if (lsu_ready !== 1'b1 || bus.req !== 1'b0 || bus.we !== 1'b0 || reg_we !== 1'b0 ||
            misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b req=%b we=%b reg_we=%b mis=%b, required 1 0 0 0 0",
                     lsu_ready, bus.req, bus.we, reg_we, misaligned);
        end
        checks++;
        if (bus.addr !== 32'd0 || bus.be !== 4'd0 || bus.wdata !== 32'd0 || wr_addr !== 5'd0 ||
            rd_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: addr=%h be=%b wdata=%h wr_addr=%0d rd_wdata=%h, required 0",
                     bus.addr, bus.be, bus.wdata, wr_addr, rd_wdata);
        end
        #2 rst_ni = 1'b1;
        step();
    endtask

    task automatic test_lw();
        run_op(1'b0, 2, 1'b0, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (o_req !== 1'b1 || o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0 ||
            o_ready_post !== 1'b0) begin
            failures++;
            $display("FAIL lw_bus: req=%b addr=%h be=%b we=%b ready=%b, required 1 100 1111 0 0",
                     o_req, o_addr, o_be, o_we, o_ready_post);
        end
        checks++;
        if (o_reg_we !== 1'b1 || o_wraddr !== 5'd5 || o_rdwdata !== 32'hDEAD_BEEF ||
            o_ready_after !== 1'b1) begin
            failures++;
            $display("FAIL lw_wb: reg_we=%b wr_addr=%0d data=%h ready=%b, required 1 5 deadbeef 1",
                     o_reg_we, o_wraddr, o_rdwdata, o_ready_after);
        end
        step();
        checks++;
        if (reg_we !== 1'b0 || rd_wdata !== 32'hDEAD_BEEF || wr_addr !== 5'd5) begin
            failures++;
            $display("FAIL lw_pulse_hold: reg_we=%b data=%h wr_addr=%0d, required 0 deadbeef 5",
                     reg_we, rd_wdata, wr_addr);
        end
    endtask

    task automatic test_lb();
        run_op(1'b0, 0, 1'b1, 32'h103, 32'h0, 5'd9, 0, 0, 32'h80FF_FFFF, 1'b0);
        checks++;
        if (o_be !== 4'b1000 || o_addr !== 32'h100 || o_rdwdata !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL lb: be=%b addr=%h data=%h, required 1000 100 ffffff80",
                     o_be, o_addr, o_rdwdata);
        end
        run_op(1'b0, 0, 1'b0, 32'h103, 32'h0, 5'd9, 0, 0, 32'h80FF_FFFF, 1'b0);
        checks++;
        if (o_rdwdata !== 32'h0000_0080 || o_reg_we !== 1'b1) begin
            failures++;
            $display("FAIL lbu: data=%h reg_we=%b, required 00000080 1", o_rdwdata, o_reg_we);
        end
    endtask

    task automatic test_sh();
        run_op(1'b1, 1, 1'b0, 32'h202, 32'h1234_ABCD, 5'd3, 0, 0, 32'h5555_5555, 1'b0);
        checks++;
        if (o_addr !== 32'h200 || o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_we !== 1'b1) begin
            failures++;
            $display("FAIL sh_bus: addr=%h be=%b wdata=%h we=%b, required 200 1100 abcdabcd 1",
                     o_addr, o_be, o_wdata, o_we);
        end
        checks++;
        if (o_reg_we !== 1'b0 || o_ready_after !== 1'b1) begin
            failures++;
            $display("FAIL sh_no_wb: reg_we=%b ready=%b, required 0 1", o_reg_we, o_ready_after);
        end
    endtask

    task automatic test_misaligned();
        run_op(1'b0, 2, 1'b0, 32'h101, 32'h0, 5'd4, 0, 0, 32'h0, 1'b0);
        checks++;
        if (o_misal !== 1'b1 || o_req !== 1'b0 || o_ready_post !== 1'b1) begin
            failures++;
            $display("FAIL misaligned: pulse=%b req=%b ready=%b, required 1 0 1",
                     o_misal, o_req, o_ready_post);
        end
        // Accepted right behind the misaligned op; the pulse must be gone by then.
        run_op(1'b0, 1, 1'b1, 32'h102, 32'h0, 5'd6, 0, 0, 32'h8001_0000, 1'b0);
        checks++;
        if (o_wait != 0 || o_misal !== 1'b0 || o_req !== 1'b1 || o_be !== 4'b1100 ||
            o_rdwdata !== 32'hFFFF_8001) begin
            failures++;
            $display("FAIL misaligned_next: wait=%0d pulse=%b req=%b be=%b data=%h, required 0 0 1 1100 ffff8001",
                     o_wait, o_misal, o_req, o_be, o_rdwdata);
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 2, 1'b0, 32'h300, 32'hCAFE_F00D, 5'd2, 4, 2, 32'h0, 1'b1);
        checks++;
        if (o_stable !== 1'b1 || o_wdata !== 32'hCAFE_F00D || o_reg_we !== 1'b0 ||
            o_ready_after !== 1'b1) begin
            failures++;
            $display("FAIL stall_stable: stable=%b wdata=%h reg_we=%b ready=%b, required 1 cafef00d 0 1",
                     o_stable, o_wdata, o_reg_we, o_ready_after);
        end
        run_op(1'b0, 2, 1'b0, 32'h404, 32'h0, 5'd31, 0, 0, 32'h1357_9BDF, 1'b0);
        checks++;
        if (o_wait != 0 || o_req !== 1'b1 || o_addr !== 32'h404 || o_rdwdata !== 32'h1357_9BDF) begin
            failures++;
            $display("FAIL back_to_back: wait=%0d req=%b addr=%h data=%h, required 0 1 404 13579bdf",
                     o_wait, o_req, o_addr, o_rdwdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rdata;
        for (int k = 0; k < 2; k++) begin
            ex_valid = 1'b1;
            lsu_we   = 1'b0;
            lsu_type = LSU_WORD;
            lsu_sext = 1'b0;
            lsu_addr = 32'h500;
            rd_addr  = 5'd7;
            step();
            ex_valid = 1'b0;
            if (k == 1) begin
                bus.gnt = 1'b1;
                step();
                bus.gnt = 1'b0;
            end
            #2 rst_ni = 1'b0;
            #1;
            checks++;
            if (bus.req !== 1'b0 || lsu_ready !== 1'b1 || bus.addr !== 32'd0 || bus.be !== 4'd0 ||
                rd_wdata !== 32'd0) begin
                failures++;
                $display("FAIL reset_mid_%0d: req=%b ready=%b addr=%h be=%b data=%h, required 0 1 0 0 0",
                         k, bus.req, lsu_ready, bus.addr, bus.be, rd_wdata);
            end
            #2 rst_ni = 1'b1;
            step();
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hA5A5_A5A5;
            step();
            bus.rvalid = 1'b0;
            step();
            checks++;
            if (reg_we !== 1'b0 || rd_wdata !== 32'd0 || lsu_ready !== 1'b1) begin
                failures++;
                $display("FAIL late_rvalid_%0d: reg_we=%b data=%h ready=%b, required 0 0 1",
                         k, reg_we, rd_wdata, lsu_ready);
            end
        end
        rdata = $urandom;
        run_op(1'b0, 2, 1'b0, 32'h600, 32'h0, 5'd0, 1, 1, rdata, 1'b0);
        checks++;
        if (o_reg_we !== 1'b0 || o_rdwdata !== rdata || o_ready_after !== 1'b1) begin
            failures++;
            $display("FAIL lw_rd0: reg_we=%b data=%h ready=%b, required 0 %h 1",
                     o_reg_we, o_rdwdata, o_ready_after, rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit          we, sext;
            int          t, off, gw, rw;
            logic [31:0] addr, wdata, rdata;
            logic [4:0]  rd;
            we    = 1'($urandom);
            sext  = 1'($urandom);
            t     = int'($urandom_range(0, 2));
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            rd    = 5'($urandom);
            gw    = int'($urandom_range(0, 3));
            rw    = int'($urandom_range(0, 3));
            off   = int'(addr[1:0]);
            run_op(we, t, sext, addr, wdata, rd, gw, rw, rdata, 1'b1);
            checks++;
            if (!o_ready_ok) begin
                failures++;
                $display("FAIL rand_ready[%0d]: lsu_ready_o stayed low, required 1", n);
            end
            if (m_misal(t, off)) begin
                checks++;
                if (o_misal !== 1'b1 || o_req !== 1'b0 || o_ready_post !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_misal[%0d]: pulse=%b req=%b ready=%b, required 1 0 1",
                             n, o_misal, o_req, o_ready_post);
                end
            end else begin
                checks++;
                if (o_req !== 1'b1 || o_misal !== 1'b0 || o_we !== we ||
                    o_addr !== (addr & 32'hFFFF_FFFC) || o_be !== m_be(t, off) ||
                    o_wdata !== m_wdata(t, wdata) || o_stable !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_bus[%0d]: req=%b we=%b addr=%h be=%b wdata=%h stable=%b, required 1 %b %h %b %h 1",
                             n, o_req, o_we, o_addr, o_be, o_wdata, o_stable, we,
                             addr & 32'hFFFF_FFFC, m_be(t, off), m_wdata(t, wdata));
                end
                checks++;
                if (o_reg_we !== (!we && rd != 5'd0) || o_ready_after !== 1'b1 ||
                    (!we && (o_wraddr !== rd || o_rdwdata !== m_load(t, sext, off, rdata)))) begin
                    failures++;
                    $display("FAIL rand_wb[%0d]: reg_we=%b wr_addr=%0d data=%h ready=%b, required %b %0d %h 1",
                             n, o_reg_we, o_wraddr, o_rdwdata, o_ready_after,
                             !we && rd != 5'd0, rd, m_load(t, sext, off, rdata));
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_ni     = 1'b0;
        ex_valid   = 1'b0;
        lsu_we     = 1'b0;
        lsu_type   = LSU_BYTE;
        lsu_sext   = 1'b0;
        lsu_addr   = 32'd0;
        lsu_wdata  = 32'd0;
        rd_addr    = 5'd0;
        bus.gnt    = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = 32'd0;
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
